// File: rtl/hd_gen_pkg.sv
// Shared types for the Hamming-distance pair generator.
// Holds the FSM state encoding and the default LFSR taps.
package hd_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [7:0] DEF_TAPS = 8'hB8;

endpackage

// File: rtl/hd_next_mask.sv
// Next mask of equal popcount (Gosper) plus last-mask detect.
// Ports: mask in, k in (weight), nxt out, last out.
module hd_next_mask
  import hd_gen_pkg::*;
#(
  parameter int BIT = 8
) (
  input  logic [BIT-1:0] mask,
  input  logic [3:0]     k,
  output logic [BIT-1:0] nxt,
  output logic           last
);

  localparam int TZW = $clog2(BIT + 1);

  logic [BIT:0]     m;
  logic [BIT:0]     c;
  logic [BIT:0]     r;
  logic [BIT:0]     x;
  logic [TZW-1:0]   tz;
  logic [BIT-1:0]   ones;

  always_comb begin
    m    = {1'b0, mask};
    c    = m & (-m);
    r    = m + c;
    tz   = '0;
    // c is one-hot, so its bit index is the trailing-zero count
    for (int i = 0; i <= BIT; i++) begin
      if (c[i]) tz = TZW'(i);
    end
    x    = ((r ^ m) >> 2) >> tz;
    nxt  = BIT'(x | r);
    ones = '1;
    // last mask has the top k bits set
    last = (mask == ~(ones >> k));
  end

endmodule

// File: rtl/hd_pair_gen.sv
// Emits (a,b) pairs at exact Hamming distance k over all weight-k masks.
// Ports: clk, rst, start/weight/seed in; out_valid/out_ready handshake;
// a, b, exp_f pair data; busy, done, err, pair_cnt status.
module hd_pair_gen
  import hd_gen_pkg::*;
#(
  parameter int             BIT  = 8,
  parameter int             MHD  = 3,
  parameter logic [BIT-1:0] TAPS = BIT'(DEF_TAPS),
  parameter int             CW   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [3:0]     weight,
  input  logic [BIT-1:0] seed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [BIT-1:0] a,
  output logic [BIT-1:0] b,
  output logic           exp_f,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [CW-1:0]  pair_cnt
);

  localparam logic [BIT:0]   ONE  = 1;
  localparam logic [BIT-1:0] ONEB = 1;

  state_t         state;
  logic [BIT-1:0] lfsr;
  logic [BIT-1:0] mask;
  logic [3:0]     k;
  logic [BIT-1:0] lfsr_n;
  logic [BIT-1:0] mask_n;
  logic [BIT-1:0] seed0;
  logic [BIT-1:0] first;
  logic           last;
  logic           hs;
  logic           kbad;
  logic           kexp;

  hd_next_mask #(.BIT(BIT)) u_next (
    .mask (mask),
    .k    (k),
    .nxt  (mask_n),
    .last (last)
  );

  assign lfsr_n = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign seed0  = (seed == '0) ? ONEB : seed;
  assign first  = BIT'((ONE << weight) - ONE);
  assign hs     = out_valid & out_ready;
  assign kbad   = int'(weight) > BIT;
  assign kexp   = int'(weight) > MHD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      a         <= '0;
      b         <= '0;
      mask      <= '0;
      pair_cnt  <= '0;
      lfsr      <= ONEB;
      exp_f     <= 1'b0;
      k         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            err      <= kbad;
            exp_f    <= kexp;
            pair_cnt <= '0;
            k        <= weight;
            if (kbad) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              lfsr      <= seed0;
              mask      <= first;
              a         <= seed0;
              b         <= seed0 ^ first;
            end
          end
        end
        RUN: begin
          if (hs) begin
            pair_cnt <= pair_cnt + CW'(1);
            lfsr     <= lfsr_n;
            if (last) begin
              state     <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              out_valid <= 1'b0;
            end else begin
              mask <= mask_n;
              a    <= lfsr_n;
              b    <= lfsr_n ^ mask_n;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
